// File: rtl/reset_sequencer_pkg.sv
// Shared configuration constants and FSM state encoding for the board reset sequencer.
// The top module and any debug decoders of state_out import this package.
package reset_sequencer_pkg;

    localparam int RESET_HOLD_CYCLES         = 1024;
    localparam int RESET_STAGGER_CYCLES      = 16;
    localparam int BTN_DEBOUNCE_CYCLES       = 270000;
    localparam int SDRAM_INIT_TIMEOUT_CYCLES = 27000000;

    typedef enum logic [2:0] {
        WAIT_READY = 3'd0,
        HOLD       = 3'd1,
        RUN_RAMIO  = 3'd2,
        RUN        = 3'd3,
        FAULT      = 3'd4
    } seq_state_e;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/reset_sequencer_synchronizer.sv
// Two-flop synchronizer for asynchronous level inputs; clears to zero on rst.
module reset_sequencer_synchronizer #(
    parameter int Width = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] meta_r;
    logic [Width-1:0] sync_r;

    // two-stage capture of the asynchronous inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= {Width{1'b0}};
            sync_r <= {Width{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/reset_sequencer.sv
// Board reset sequencer: releases ramio then core once PLL lock and SDRAM init are stable.
// Define RESET_SEQUENCER_BTN_EN to build the debounced btn1 restart path.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int HoldCycles        = RESET_HOLD_CYCLES,
    parameter int StaggerCycles     = RESET_STAGGER_CYCLES,
    parameter int DebounceCycles    = BTN_DEBOUNCE_CYCLES,
    parameter int InitTimeoutCycles = SDRAM_INIT_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rpll_lock,
    input  logic       sdram_init_done,
    input  logic       btn1,
    output logic       ramio_rst_n,
    output logic       core_rst_n,
    output logic       fault,
    output logic [2:0] state_out
);

    localparam int CNT_W = $clog2(max_of4(HoldCycles, StaggerCycles,
                                          DebounceCycles, InitTimeoutCycles)) + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HoldCycles);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(StaggerCycles - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(InitTimeoutCycles - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) sat_inc = v;
        else              sat_inc = v + CNT_ONE;
    endfunction

    logic [1:0]       ready_sync_s;
    logic             ready_s;
    logic             press_s;
    seq_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ramio_r;
    logic             core_r;
    logic             fault_r;

    reset_sequencer_synchronizer #(.Width(2)) u_ready_sync (
        .clk (clk),
        .rst (rst),
        .d   ({rpll_lock, sdram_init_done}),
        .q   (ready_sync_s)
    );

    assign ready_s = &ready_sync_s;

`ifdef RESET_SEQUENCER_BTN_EN
    localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DebounceCycles - 1);

    logic             btn_sync_s;
    logic             btn_level_r;
    logic [CNT_W-1:0] db_cnt_r;
    logic             press_r;

    reset_sequencer_synchronizer #(.Width(1)) u_btn_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn1),
        .q   (btn_sync_s)
    );

    // level flips after DebounceCycles consecutive disagreeing samples; press_r marks a rising flip
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_level_r <= 1'b0;
            db_cnt_r    <= CNT_ZERO;
            press_r     <= 1'b0;
        end else if (btn_sync_s == btn_level_r) begin
            db_cnt_r <= CNT_ZERO;
            press_r  <= 1'b0;
        end else if (db_cnt_r == DEBOUNCE_LAST) begin
            btn_level_r <= btn_sync_s;
            db_cnt_r    <= CNT_ZERO;
            press_r     <= btn_sync_s;
        end else begin
            db_cnt_r <= sat_inc(db_cnt_r);
            press_r  <= 1'b0;
        end
    end

    assign press_s = press_r;
`else
    logic btn_unused_s;
    assign btn_unused_s = btn1;
    assign press_s      = 1'b0;
`endif

    // sequencing FSM; the reset outputs are registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= WAIT_READY;
            cnt_r   <= CNT_ZERO;
            ramio_r <= 1'b0;
            core_r  <= 1'b0;
            fault_r <= 1'b0;
        end else if (press_s) begin
            state_r <= WAIT_READY;
            cnt_r   <= CNT_ZERO;
            ramio_r <= 1'b0;
            core_r  <= 1'b0;
            fault_r <= 1'b0;
        end else begin
            case (state_r)
                WAIT_READY: begin
                    ramio_r <= 1'b0;
                    core_r  <= 1'b0;
                    if (ready_s) begin
                        state_r <= HOLD;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        state_r <= FAULT;
                        cnt_r   <= CNT_ZERO;
                        fault_r <= 1'b1;
                    end else begin
                        cnt_r <= sat_inc(cnt_r);
                    end
                end
                HOLD: begin
                    if (!ready_s) begin
                        state_r <= WAIT_READY;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r == HOLD_LAST) begin
                        state_r <= RUN_RAMIO;
                        cnt_r   <= CNT_ZERO;
                        ramio_r <= 1'b1;
                    end else begin
                        cnt_r <= sat_inc(cnt_r);
                    end
                end
                RUN_RAMIO: begin
                    if (!ready_s) begin
                        state_r <= WAIT_READY;
                        cnt_r   <= CNT_ZERO;
                        ramio_r <= 1'b0;
                        core_r  <= 1'b0;
                    end else if (cnt_r == STAGGER_LAST) begin
                        state_r <= RUN;
                        cnt_r   <= CNT_ZERO;
                        core_r  <= 1'b1;
                    end else begin
                        cnt_r <= sat_inc(cnt_r);
                    end
                end
                RUN: begin
                    if (!ready_s) begin
                        state_r <= WAIT_READY;
                        cnt_r   <= CNT_ZERO;
                        ramio_r <= 1'b0;
                        core_r  <= 1'b0;
                    end else begin
                        cnt_r <= CNT_ZERO;
                    end
                end
                FAULT: begin
                    ramio_r <= 1'b0;
                    core_r  <= 1'b0;
                    fault_r <= 1'b1;
                end
                default: begin
                    state_r <= WAIT_READY;
                    cnt_r   <= CNT_ZERO;
                    ramio_r <= 1'b0;
                    core_r  <= 1'b0;
                    fault_r <= 1'b0;
                end
            endcase
        end
    end

    assign ramio_rst_n = ramio_r;
    assign core_rst_n  = core_r;
    assign fault       = fault_r;
    assign state_out   = state_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: an elapsed-time reference model queues expected
// output changes, a negedge monitor pops and compares them whenever the outputs change.
`timescale 1ns/1ps
module tb_reset_sequencer;
    import reset_sequencer_pkg::*;

    localparam int P_HOLD     = 8;
    localparam int P_STAGGER  = 4;
    localparam int P_DEBOUNCE = 16;
    localparam int P_TIMEOUT  = 100;

    logic       clk             = 1'b0;
    logic       rst             = 1'b1;
    logic       rpll_lock       = 1'b0;
    logic       sdram_init_done = 1'b0;
    logic       btn1            = 1'b0;
    logic       ramio_rst_n;
    logic       core_rst_n;
    logic       fault;
    logic [2:0] state_out;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int         cyc;
        logic [5:0] val;
    } ev_t;
    ev_t exp_q[$];

    reset_sequencer #(
        .HoldCycles        (P_HOLD),
        .StaggerCycles     (P_STAGGER),
        .DebounceCycles    (P_DEBOUNCE),
        .InitTimeoutCycles (P_TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rpll_lock       (rpll_lock),
        .sdram_init_done (sdram_init_done),
        .btn1            (btn1),
        .ramio_rst_n     (ramio_rst_n),
        .core_rst_n      (core_rst_n),
        .fault           (fault),
        .state_out       (state_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // inputs were just made ready; the next posedge is edge 0
    task automatic boot_sequence(input string tag);
        step(11);
        check({tag, "_ramio_edge10"}, ramio_rst_n, 1'b0);
        step(1);
        check({tag, "_ramio_edge11"}, ramio_rst_n, 1'b1);
        check({tag, "_core_edge11"}, core_rst_n, 1'b0);
        step(3);
        check({tag, "_core_edge14"}, core_rst_n, 1'b0);
        step(1);
        check({tag, "_core_edge15"}, core_rst_n, 1'b1);
        check({tag, "_fault"}, fault, 1'b0);
    endtask

    // Reference model: phases with durations measured in edges since phase entry.
    initial begin : ref_model
        seq_state_e ph;
        int         age;
        logic [1:0] lock_p, init_p;
        logic       ready, press;
        logic [5:0] cur, prev;
        int         tag;
`ifdef RESET_SEQUENCER_BTN_EN
        logic [1:0] btn_p;
        logic       lvl, pend;
        int         run;
        btn_p = 2'b00; lvl = 1'b0; pend = 1'b0; run = 0;
`endif
        ph = WAIT_READY; age = 0; lock_p = 2'b00; init_p = 2'b00;
        prev = 6'b0; tag = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                ph = WAIT_READY; age = 0; lock_p = 2'b00; init_p = 2'b00;
`ifdef RESET_SEQUENCER_BTN_EN
                btn_p = 2'b00; lvl = 1'b0; pend = 1'b0; run = 0;
`endif
                tag = (clk === 1'b1) ? cyc : cyc + 1;
            end else begin
                ready = lock_p[1] & init_p[1];
`ifdef RESET_SEQUENCER_BTN_EN
                press = pend;
`else
                press = 1'b0;
`endif
                age++;
                if (press) begin
                    ph = WAIT_READY; age = 0;
                end else begin
                    case (ph)
                        WAIT_READY:
                            if (ready) begin ph = HOLD; age = 0; end
                            else if (age == P_TIMEOUT) begin ph = FAULT; age = 0; end
                        HOLD:
                            if (!ready) begin ph = WAIT_READY; age = 0; end
                            else if (age == P_HOLD + 1) begin ph = RUN_RAMIO; age = 0; end
                        RUN_RAMIO:
                            if (!ready) begin ph = WAIT_READY; age = 0; end
                            else if (age == P_STAGGER) begin ph = RUN; age = 0; end
                        RUN:
                            if (!ready) begin ph = WAIT_READY; age = 0; end
                        default: ph = ph;
                    endcase
                end
`ifdef RESET_SEQUENCER_BTN_EN
                if (btn_p[1] != lvl) run++;
                else run = 0;
                pend = 1'b0;
                if (run == P_DEBOUNCE) begin
                    lvl = btn_p[1]; run = 0; pend = lvl;
                end
                btn_p = {btn_p[0], btn1};
`endif
                lock_p = {lock_p[0], rpll_lock};
                init_p = {init_p[0], sdram_init_done};
                tag = cyc + 1;
            end
            cur = {(ph == RUN_RAMIO) || (ph == RUN), ph == RUN, ph == FAULT, ph};
            if (cur != prev) begin
                exp_q.push_back('{tag, cur});
                prev = cur;
            end
        end
    end

    // Monitor: pops an expected event whenever the DUT outputs change.
    initial begin : monitor
        logic [5:0] seen, last;
        ev_t        e;
        last = 6'b0;
        forever begin
            @(negedge clk);
            seen = {ramio_rst_n, core_rst_n, fault, state_out};
            n_vec++;
            if (core_rst_n === 1'b1 && ramio_rst_n !== 1'b1) begin
                n_err++;
                $display("FAIL invariant: core_rst_n=%b with ramio_rst_n=%b (cycle %0d), required ramio high", core_rst_n, ramio_rst_n, cyc);
            end
            if (seen !== last) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_change: got %b at cycle %0d, expected no change", seen, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.val !== seen) begin
                        n_err++;
                        $display("FAIL output_event: got %b at cycle %0d, expected %b at cycle %0d", seen, cyc, e.val, e.cyc);
                    end
                end
                last = seen;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: stimulus did not complete, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int r;
        step(3);
        check("reset_ramio", ramio_rst_n, 1'b0);
        check("reset_core", core_rst_n, 1'b0);
        check("reset_fault", fault, 1'b0);
        check("reset_state", state_out, WAIT_READY);
        rst = 1'b0;
        step(2);

        rpll_lock = 1'b1; sdram_init_done = 1'b1;
        boot_sequence("boot");

        step(5);
        rpll_lock = 1'b0;
        step(3);
        check("lock_drop_ramio", ramio_rst_n, 1'b0);
        check("lock_drop_core", core_rst_n, 1'b0);
        rpll_lock = 1'b1;
        boot_sequence("relock");

        rpll_lock = 1'b0; sdram_init_done = 1'b0;
        step(4);
        rpll_lock = 1'b1; sdram_init_done = 1'b1;
        step(6);
        check("glitch_in_hold", state_out, HOLD);
        sdram_init_done = 1'b0;
        step(1);
        sdram_init_done = 1'b1;
        boot_sequence("glitch");

        sdram_init_done = 1'b0;
        step(115);
        check("timeout_fault", fault, 1'b1);
        check("timeout_state", state_out, FAULT);
        check("timeout_ramio", ramio_rst_n, 1'b0);
        check("timeout_core", core_rst_n, 1'b0);
        sdram_init_done = 1'b1;
        step(30);
        check("fault_sticky_state", state_out, FAULT);
        check("fault_sticky_flag", fault, 1'b1);

        rst = 1'b1;
        step(2);
        rst = 1'b0;
        boot_sequence("rst_from_fault");

        step(3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_ramio", ramio_rst_n, 1'b0);
        check("async_rst_core", core_rst_n, 1'b0);
        step(2);
        rst = 1'b0;
        boot_sequence("after_async_rst");

        step(5);
        for (int i = 0; i < 8; i++) begin
            btn1 = 1'b1; step(3);
            btn1 = 1'b0; step(2);
        end
        check("bounce_state", state_out, RUN);
        check("bounce_core", core_rst_n, 1'b1);
        btn1 = 1'b1;
        step(20);
        btn1 = 1'b0;
        step(2);
`ifdef RESET_SEQUENCER_BTN_EN
        check("press_ramio", ramio_rst_n, 1'b0);
        check("press_core", core_rst_n, 1'b0);
        check("press_fault", fault, 1'b0);
`else
        check("btn_ignored_state", state_out, RUN);
`endif

        step(40);
        sdram_init_done = 1'b0;
        step(115);
        check("fault_before_btn", state_out, FAULT);
        btn1 = 1'b1;
        step(20);
        btn1 = 1'b0;
        step(2);
`ifdef RESET_SEQUENCER_BTN_EN
        check("btn_clears_fault", fault, 1'b0);
        check("btn_exit_state", state_out, WAIT_READY);
`else
        check("btn_no_exit_state", state_out, FAULT);
`endif

        rst = 1'b1;
        step(2);
        rst = 1'b0;
        sdram_init_done = 1'b1;
        step(20);

        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 999);
            if (r < 8) begin
                rpll_lock = ~rpll_lock;
            end else if (r < 20) begin
                sdram_init_done = ~sdram_init_done;
            end else if (r < 35) begin
                btn1 = ~btn1;
            end else if (r < 37) begin
                if (r == 36) begin
                    @(posedge clk);
                    #3;
                end
                rst = 1'b1;
                step($urandom_range(1, 3));
                rst = 1'b0;
            end
            step(1);
        end

        step(5);
        check("scoreboard_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
